req_capture_stage: RTL and testbench

- Upstream companion to the N-bit priority encoder.
- Turns 2**N raw level-sensitive request lines into sticky pending bits via rising-edge detection, and applies a per-line mask.
- Presents the masked pending vector to the encoder. Internally selects the highest-priority pending line and offers its index on a valid/ready handshake.
- Clears the served pending bit on acceptance, so each request edge is delivered exactly once.

---
 rtl/req_capture_stage_pkg.sv | 10 +
 rtl/req_capture_stage_pick_highest.sv | 24 ++
 rtl/req_capture_stage.sv | 100 ++++++++++
 tb/tb_req_capture_stage.sv | 147 ++++++++++++++
 4 files changed

// File: rtl/req_capture_stage_pkg.sv
// Shared types and helpers for the request capture stage.
package req_capture_stage_pkg;

  typedef enum logic [0:0] {IDLE, OFFER} cap_state_t;

  function automatic int line_cnt(input int n);
    return 1 << n;
  endfunction

endpackage

// File: rtl/req_capture_stage_pick_highest.sv
// Combinational highest-set-bit index plus any-set flag; zero latency.
module pick_highest
  import req_capture_stage_pkg::*;
#(
  parameter int N = 3
) (
  input  logic [line_cnt(N)-1:0] vec,
  output logic [N-1:0]           idx,
  output logic                   any
);

  always_comb begin
    idx = '0;
    any = 1'b0;
    // Ascending scan so the last (highest) set bit overrides lower ones.
    for (int i = 0; i < line_cnt(N); i++) begin
      if (vec[i]) begin
        idx = i[N-1:0];
        any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/req_capture_stage.sv
// Captures request rising edges into sticky pending bits and offers the highest eligible index on valid/ready.
// Edge to pending 1 cycle, to out_valid 2 cycles; an offer holds until out_ready, then one IDLE cycle before the next.
module req_capture_stage
  import req_capture_stage_pkg::*;
#(
  parameter int N     = 3,
  parameter int CNT_W = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   enable,
  input  logic [line_cnt(N)-1:0] req,
  input  logic [line_cnt(N)-1:0] mask,
  output logic [line_cnt(N)-1:0] pend_vec,
  output logic                   out_valid,
  output logic [N-1:0]           out_idx,
  input  logic                   out_ready,
  output logic [CNT_W-1:0]       ovf_cnt
);

  localparam int L = line_cnt(N);

  cap_state_t       state_q, state_d;
  logic [L-1:0]     req_q, req_d;
  logic [L-1:0]     pending_q, pending_d;
  logic [L-1:0]     pend_vec_q, pend_vec_d;
  logic [N-1:0]     out_idx_q, out_idx_d;
  logic [CNT_W-1:0] ovf_cnt_q, ovf_cnt_d;

  logic [L-1:0] rise;
  logic [L-1:0] clr;
  logic         accept;
  logic [N-1:0] sel_idx;
  logic         sel_any;

  // Selection runs over the registered pend_vec, i.e. exactly what the encoder sees,
  // so a mask change takes effect on offers one cycle after it is applied.
  pick_highest #(.N(N)) u_pick (
    .vec (pend_vec_q),
    .idx (sel_idx),
    .any (sel_any)
  );

  always_comb begin
    accept = (state_q == OFFER) && out_ready;
    rise   = req & ~req_q;
    req_d  = req;

    clr = '0;
    clr[out_idx_q] = accept;

    // Set wins over clear so an edge on the accept cycle is re-offered later.
    pending_d  = rise | (pending_q & ~clr);
    pend_vec_d = pending_d & mask;

    ovf_cnt_d = ovf_cnt_q;
    if ((|(rise & pending_q & ~clr)) && (ovf_cnt_q != {CNT_W{1'b1}})) begin
      ovf_cnt_d = ovf_cnt_q + 1'b1;
    end

    state_d   = state_q;
    out_idx_d = out_idx_q;
    unique case (state_q)
      IDLE: begin
        if (enable && sel_any) begin
          out_idx_d = sel_idx;
          state_d   = OFFER;
        end
      end
      OFFER: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      req_q      <= '0;
      pending_q  <= '0;
      pend_vec_q <= '0;
      out_idx_q  <= '0;
      ovf_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      req_q      <= req_d;
      pending_q  <= pending_d;
      pend_vec_q <= pend_vec_d;
      out_idx_q  <= out_idx_d;
      ovf_cnt_q  <= ovf_cnt_d;
    end
  end

  assign pend_vec  = pend_vec_q;
  assign out_valid = (state_q == OFFER);
  assign out_idx   = out_idx_q;
  assign ovf_cnt   = ovf_cnt_q;

endmodule

// File: tb/tb_req_capture_stage.sv
// Directed self-checking bench for req_capture_stage (N=3, CNT_W=2).
module tb_req_capture_stage;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       enable;
  logic [7:0] req;
  logic [7:0] mask;
  logic [7:0] pend_vec;
  logic       out_valid;
  logic [2:0] out_idx;
  logic       out_ready;
  logic [1:0] ovf_cnt;

  int n_cmp = 0;
  int n_err = 0;

  req_capture_stage #(.N(3), .CNT_W(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .enable    (enable),
    .req       (req),
    .mask      (mask),
    .pend_vec  (pend_vec),
    .out_valid (out_valid),
    .out_idx   (out_idx),
    .out_ready (out_ready),
    .ovf_cnt   (ovf_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic v, input logic [2:0] idx,
                         input logic [7:0] pv);
    chk({tag, ".valid"}, {31'd0, out_valid}, {31'd0, v});
    if (v) chk({tag, ".idx"}, {29'd0, out_idx}, {29'd0, idx});
    chk({tag, ".pend"}, {24'd0, pend_vec}, {24'd0, pv});
  endtask

  initial begin
    rst_n = 1'b0; enable = 1'b1; req = 8'hFF; mask = 8'hFF; out_ready = 1'b0;

    // Reset with all requests high: outputs held at zero.
    tick();
    chk_out("rst0", 1'b0, 3'd0, 8'h00);
    chk("rst0.idx", {29'd0, out_idx}, 32'd0);
    chk("rst0.ovf", {30'd0, ovf_cnt}, 32'd0);
    tick();
    chk_out("rst1", 1'b0, 3'd0, 8'h00);
    rst_n = 1'b1;
    tick();
    chk_out("rel_pend", 1'b0, 3'd0, 8'hFF);
    tick();
    chk_out("rel_offer", 1'b1, 3'd7, 8'hFF);

    // Reset mid-offer discards the offer and every pending bit.
    rst_n = 1'b0; req = 8'h00;
    tick();
    chk_out("rst_mid", 1'b0, 3'd0, 8'h00);
    rst_n = 1'b1;
    tick();
    chk_out("rst_after", 1'b0, 3'd0, 8'h00);

    // Priority and drain: lines 1,4,6 together, consumer always ready.
    out_ready = 1'b1; req = 8'h52;
    tick(); req = 8'h00;
    chk_out("drn_p", 1'b0, 3'd0, 8'h52);
    tick(); chk_out("drn_o6", 1'b1, 3'd6, 8'h52);
    tick(); chk_out("drn_a6", 1'b0, 3'd0, 8'h12);
    tick(); chk_out("drn_o4", 1'b1, 3'd4, 8'h12);
    tick(); chk_out("drn_a4", 1'b0, 3'd0, 8'h02);
    tick(); chk_out("drn_o1", 1'b1, 3'd1, 8'h02);
    tick(); chk_out("drn_a1", 1'b0, 3'd0, 8'h00);
    tick(); chk_out("drn_idle", 1'b0, 3'd0, 8'h00);
    chk("drn.ovf", {30'd0, ovf_cnt}, 32'd0);

    // Backpressure: offer of line 2 held through new request, mask and enable changes.
    out_ready = 1'b0; req = 8'h04;
    tick(); req = 8'h00;
    tick(); chk_out("bp_o2", 1'b1, 3'd2, 8'h04);
    req = 8'h80;
    tick(); req = 8'h00; chk_out("bp_h0", 1'b1, 3'd2, 8'h84);
    mask = 8'h00;
    tick(); chk_out("bp_h1", 1'b1, 3'd2, 8'h00);
    enable = 1'b0;
    tick(); chk_out("bp_h2", 1'b1, 3'd2, 8'h00);
    tick(); chk_out("bp_h3", 1'b1, 3'd2, 8'h00);
    tick(); chk_out("bp_h4", 1'b1, 3'd2, 8'h00);
    out_ready = 1'b1;
    tick(); chk_out("bp_acc", 1'b0, 3'd0, 8'h00);
    tick(); chk_out("bp_wait", 1'b0, 3'd0, 8'h00);
    mask = 8'hFF;
    tick(); chk_out("bp_mask", 1'b0, 3'd0, 8'h80);
    enable = 1'b1;
    tick(); chk_out("bp_o7", 1'b1, 3'd7, 8'h80);
    tick(); chk_out("bp_a7", 1'b0, 3'd0, 8'h00);

    // Set/clear collision on line 3.
    out_ready = 1'b0; req = 8'h08;
    tick(); req = 8'h00;
    tick(); chk_out("col_o3", 1'b1, 3'd3, 8'h08);
    out_ready = 1'b1; req = 8'h08;
    tick(); chk_out("col_acc", 1'b0, 3'd0, 8'h08);
    chk("col.ovf", {30'd0, ovf_cnt}, 32'd0);
    out_ready = 1'b0;
    tick(); chk_out("col_re3", 1'b1, 3'd3, 8'h08);
    req = 8'h00; out_ready = 1'b1;
    tick(); chk_out("col_a3", 1'b0, 3'd0, 8'h00);
    chk("col.ovf2", {30'd0, ovf_cnt}, 32'd0);

    // Masked line 0 stays pending and unserved; repeated edges saturate ovf_cnt.
    out_ready = 1'b0; mask = 8'hFE; req = 8'h01;
    tick(); req = 8'h00;
    tick(); chk_out("msk_p", 1'b0, 3'd0, 8'h00);
    for (int k = 0; k < 5; k++) begin
      req = 8'h01;
      tick();
      chk($sformatf("ovf%0d", k), {30'd0, ovf_cnt}, (k < 2) ? k + 1 : 3);
      req = 8'h00;
      tick();
    end
    chk_out("msk_noofr", 1'b0, 3'd0, 8'h00);
    mask = 8'hFF;
    tick(); chk_out("msk_on", 1'b0, 3'd0, 8'h01);
    tick(); chk_out("msk_o0", 1'b1, 3'd0, 8'h01);
    chk("msk.ovf", {30'd0, ovf_cnt}, 32'd3);
    out_ready = 1'b1;
    tick(); chk_out("msk_a0", 1'b0, 3'd0, 8'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
